// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Registered ShiftRows / InvShiftRows stage for a Rijndael state of NB
//   columns (4, 6 or 8). The permutation is applied combinationally to the
//   incoming state and the result is captured, together with its direction
//   flag, into a 2-entry FIFO that feeds the downstream round stages.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state present
//   in_ready   stage can accept a state (depends on FIFO occupancy only)
//   in_data    input state, row-major, MSB first, 32*NB bits
//   in_inv     0 = ShiftRows, 1 = InvShiftRows
//   out_valid  head entry present
//   out_ready  downstream accepts the head entry
//   out_data   permuted state at the FIFO head
//   out_inv    direction flag paired with out_data
//   blk_count  number of states delivered on the output (wraps)
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic                out_inv,
  output logic [CNT_W-1:0]    blk_count
);

  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Byte (r,c) lives at [W-1-8*(r*NB+c) -: 8]. Every source index is a
  // constant, so the permutation reduces to a 2:1 mux per byte.
  logic [W-1:0] perm;

  genvar r, c;
  generate
    for (r = 0; r < 4; r++) begin : g_row
      // Row offsets are {0,1,2,3}, except NB=8 where rows 2 and 3 shift by 3 and 4.
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      for (c = 0; c < NB; c++) begin : g_col
        localparam int SRC_FWD = (c + OFF) % NB;
        localparam int SRC_INV = (c + NB - OFF) % NB;
        assign perm[W-1-8*(r*NB+c) -: 8] = in_inv ? in_data[W-1-8*(r*NB+SRC_INV) -: 8]
                                                  : in_data[W-1-8*(r*NB+SRC_FWD) -: 8];
      end
    end
  endgenerate

  logic [W-1:0] mem_data [2];
  logic [1:0]   mem_inv;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_inv   = mem_inv[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_inv     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      blk_count   <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= perm;
        mem_inv[wr_ptr]  <= in_inv;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        blk_count <= blk_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [255:0] in_data8 = '0;

  logic         in_ready, out_valid, out_inv;
  logic [127:0] out_data;
  logic [15:0]  blk_count;

  logic         in_ready8, out_valid8, out_inv8;
  logic [255:0] out_data8;
  logic [15:0]  blk_count8;

  logic         in_ready_w, out_valid_w, out_inv_w;
  logic [127:0] out_data_w;
  logic [1:0]   blk_count_w;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per DUT flavour; all three see the same handshake.
  logic [127:0] q_d[$];
  logic         q_i[$];
  logic [255:0] q_d8[$];
  int           exp_cnt = 0;

  localparam logic [127:0] V4_IN  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] V4_FWD = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
  localparam logic [255:0] V8_IN  = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
  localparam logic [255:0] V8_FWD = 256'h00010203_04050607_090A0B0C_0D0E0F08_13141516_17101112_1C1D1E1F_18191A1B;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .blk_count(blk_count));

  shift_rows_pipe #(.NB(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data8), .in_inv(in_inv), .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .out_inv(out_inv8), .blk_count(blk_count8));

  shift_rows_pipe #(.NB(4), .CNT_W(2)) u_dutw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_inv(out_inv_w), .blk_count(blk_count_w));

  // Split each row into a byte list, rotate it, and lay it back out.
  function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input logic inv);
    logic [7:0]   row[$];
    logic [255:0] res;
    int           offs[4];
    res = '0;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(d[nb*32-1-8*(r*nb+c) -: 8]);
      for (int k = 0; k < offs[r]; k++) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) res[nb*32-1-8*(r*nb+c) -: 8] = row[c];
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // Advance one clock and update the model with the handshakes it predicts.
  task automatic tick();
    bit push, pop;
    logic [255:0] p4, p8;
    push = in_valid && (q_d.size() < 2);
    pop  = out_ready && (q_d.size() > 0);
    p4 = ref_perm({128'b0, in_data}, 4, in_inv);
    p8 = ref_perm(in_data8, 8, in_inv);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q_d.pop_front());
      void'(q_i.pop_front());
      void'(q_d8.pop_front());
      exp_cnt++;
    end
    if (push) begin
      q_d.push_back(p4[127:0]);
      q_i.push_back(in_inv);
      q_d8.push_back(p8);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_d.delete();
    q_i.delete();
    q_d8.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (blk_count !== 16'd0) begin n_bad++; $display("FAIL reset_blk_count: got %0d want 0", blk_count); end
    n_cmp++; if (out_data !== 128'd0 || out_inv !== 1'b0) begin n_bad++; $display("FAIL reset_out_data: got %h/%b want 0/0", out_data, out_inv); end
  endtask

  task automatic test_vectors();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = V4_IN;
    in_data8  = V8_IN;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fwd4_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== V4_FWD || out_inv !== 1'b0) begin n_bad++; $display("FAIL fwd4_data: got %h/%b want %h/0", out_data, out_inv, V4_FWD); end
    n_cmp++; if (out_data8 !== V8_FWD) begin n_bad++; $display("FAIL fwd8_data: got %h want %h", out_data8, V8_FWD); end
    in_inv   = 1'b1;
    in_data  = V4_FWD;
    in_data8 = V8_FWD;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (blk_count !== 16'd1) begin n_bad++; $display("FAIL fwd4_count: got %0d want 1", blk_count); end
    n_cmp++; if (out_data !== V4_IN || out_inv !== 1'b1) begin n_bad++; $display("FAIL inv4_data: got %h/%b want %h/1", out_data, out_inv, V4_IN); end
    n_cmp++; if (out_data8 !== V8_IN || out_inv8 !== 1'b1) begin n_bad++; $display("FAIL inv8_data: got %h/%b want %h/1", out_data8, out_inv8, V8_IN); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || blk_count !== 16'd2) begin n_bad++; $display("FAIL vec_drain: got valid %b count %0d want 0/2", out_valid, blk_count); end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, c;
    logic [255:0] ea, eb, ec;
    logic         ia, ib, ic;
    do_reset();
    a = rnd128(); b = rnd128(); c = rnd128();
    ia = 1'($urandom); ib = 1'($urandom); ic = 1'($urandom);
    ea = ref_perm({128'b0, a}, 4, ia);
    eb = ref_perm({128'b0, b}, 4, ib);
    ec = ref_perm({128'b0, c}, 4, ic);
    in_valid = 1'b1; in_data = a; in_inv = ia;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a: got %b want 1", in_ready); end
    tick();
    in_data = b; in_inv = ib;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_b: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== ea[127:0] || out_inv !== ia) begin n_bad++; $display("FAIL bp_head_a: got %h/%b want %h/%b", out_data, out_inv, ea[127:0], ia); end
    tick();
    in_data = c; in_inv = ic;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: cycle %0d got %b want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== ea[127:0]) begin n_bad++; $display("FAIL bp_hold_a: cycle %0d got %b/%h want 1/%h", k, out_valid, out_data, ea[127:0]); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== eb[127:0] || out_inv !== ib) begin n_bad++; $display("FAIL bp_head_b: got %h/%b want %h/%b", out_data, out_inv, eb[127:0], ib); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== ec[127:0] || out_inv !== ic) begin n_bad++; $display("FAIL bp_head_c: got %b/%h/%b want 1/%h/%b", out_valid, out_data, out_inv, ec[127:0], ic); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || blk_count !== 16'd3) begin n_bad++; $display("FAIL bp_drain: got %b/%0d want 0/3", out_valid, blk_count); end
  endtask

  task automatic test_mixed();
    int sent = 0;
    int cyc = 0;
    do_reset();
    while ((sent < 4 || q_d.size() != 0) && cyc < 200) begin
      in_valid  = (sent < 4);
      in_inv    = sent[0];
      in_data   = rnd128();
      in_data8  = rnd256();
      out_ready = 1'($urandom);
      n_cmp++; if (out_valid !== (q_d.size() != 0)) begin n_bad++; $display("FAIL mix_valid: got %b want %b", out_valid, q_d.size() != 0); end
      if (q_d.size() != 0) begin
        n_cmp++; if (out_data !== q_d[0] || out_inv !== q_i[0]) begin n_bad++; $display("FAIL mix_data: got %h/%b want %h/%b", out_data, out_inv, q_d[0], q_i[0]); end
        n_cmp++; if (out_data8 !== q_d8[0]) begin n_bad++; $display("FAIL mix_data8: got %h want %h", out_data8, q_d8[0]); end
      end
      if (in_valid && q_d.size() < 2) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL mix_timeout: %0d cycles, %0d sent, %0d left", cyc, sent, q_d.size()); end
    n_cmp++; if (blk_count !== 16'd4) begin n_bad++; $display("FAIL mix_count: got %0d want 4", blk_count); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inv    = 1'($urandom);
      in_data   = rnd128();
      in_data8  = rnd256();
      out_ready = ($urandom_range(0, 2) != 0);
      n_cmp++; if (in_ready !== (q_d.size() != 2) || in_ready8 !== (q_d.size() != 2)) begin n_bad++; $display("FAIL rnd_ready: got %b/%b want %b", in_ready, in_ready8, q_d.size() != 2); end
      n_cmp++; if (out_valid !== (q_d.size() != 0) || out_valid8 !== (q_d.size() != 0)) begin n_bad++; $display("FAIL rnd_valid: got %b/%b want %b", out_valid, out_valid8, q_d.size() != 0); end
      if (q_d.size() != 0) begin
        n_cmp++; if (out_data !== q_d[0] || out_inv !== q_i[0]) begin n_bad++; $display("FAIL rnd_data: got %h/%b want %h/%b", out_data, out_inv, q_d[0], q_i[0]); end
        n_cmp++; if (out_data8 !== q_d8[0]) begin n_bad++; $display("FAIL rnd_data8: got %h want %h", out_data8, q_d8[0]); end
      end
      n_cmp++; if (blk_count !== 16'(exp_cnt) || blk_count_w !== 2'(exp_cnt)) begin n_bad++; $display("FAIL rnd_count: got %0d/%0d want %0d", blk_count, blk_count_w, exp_cnt); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    while (q_d.size() < 2) begin
      in_data = rnd128();
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: got ready %b valid %b want 0/1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_hs: got valid %b ready %b want 0/1", out_valid, in_ready); end
    n_cmp++; if (blk_count !== 16'd0 || out_data !== 128'd0) begin n_bad++; $display("FAIL mid_rst_regs: got %0d/%h want 0/0", blk_count, out_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_d.delete(); q_i.delete(); q_d8.delete();
    exp_cnt   = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_valid !== 1'b0 || blk_count !== 16'd0) begin n_bad++; $display("FAIL mid_after: cycle %0d got %b/%0d want 0/0", k, out_valid, blk_count); end
      tick();
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (exp_cnt < 5 && cyc < 50) begin
      in_data = rnd128();
      in_inv  = 1'($urandom);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (exp_cnt != 5) begin n_bad++; $display("FAIL wrap_timeout: %0d pops after %0d cycles", exp_cnt, cyc); end
    n_cmp++; if (blk_count_w !== 2'd1) begin n_bad++; $display("FAIL wrap_count2: got %0d want 1", blk_count_w); end
    n_cmp++; if (blk_count !== 16'd5) begin n_bad++; $display("FAIL wrap_count16: got %0d want 5", blk_count); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mixed();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
